// File: rtl/cctl_spi_master.sv
// cctl_spi_master: byte-wide mode-0 SPI master behind the CCTL register window.
// One DATA write shifts a byte out on mosi while capturing miso, MSB first.
module cctl_spi_master #(
   parameter int DIV_W = 8,
   parameter logic [DIV_W-1:0] DIV_RESET = DIV_W'(3)
) (
   input  logic       phi2,
   input  logic       reset_n,
   input  logic       sel,
   input  logic [2:0] reg_a,
   input  logic       r_w,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       sck,
   output logic       mosi,
   input  logic       miso,
   output logic       cs_n,
   output logic       busy
);
   typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;
   state_t state_q, state_d;
   logic sck_q, sck_d, mosi_q, mosi_d, cs_q, cs_d, done_q, done_d, ovr_q, ovr_d, rxbit_q, rxbit_d;
   logic [7:0] shreg_q, shreg_d, rxbuf_q, rxbuf_d;
   logic [DIV_W-1:0] div_q, div_d, divcnt_q, divcnt_d;
   logic [2:0] bitcnt_q, bitcnt_d;
   logic wr, rd_data, term;
   assign wr      = sel & ~r_w;
   assign rd_data = sel & r_w & (reg_a == 3'd0);
   assign busy    = state_q != IDLE;
   assign term    = divcnt_q >= div_q;
   assign sck     = sck_q;
   assign mosi    = mosi_q;
   assign cs_n    = ~cs_q;
   assign dout    = reg_a == 3'd0 ? rxbuf_q :
                    reg_a == 3'd1 ? {busy, done_q, ovr_q, 4'b0000, cs_q} :
                    reg_a == 3'd2 ? 8'(div_q) : 8'h00;
   always_comb begin
      state_d  = state_q;
      sck_d    = sck_q;
      mosi_d   = mosi_q;
      cs_d     = cs_q;
      done_d   = done_q;
      ovr_d    = ovr_q;
      rxbit_d  = rxbit_q;
      shreg_d  = shreg_q;
      rxbuf_d  = rxbuf_q;
      div_d    = div_q;
      divcnt_d = divcnt_q;
      bitcnt_d = bitcnt_q;
      if (rd_data) done_d = 1'b0;
      if (wr && reg_a == 3'd0 && busy) ovr_d = 1'b1;
      if (wr && reg_a == 3'd1) begin
         cs_d = din[0];
         if (din[7]) ovr_d = 1'b0;
      end
      if (wr && reg_a == 3'd2) begin
         if (busy) ovr_d = 1'b1;
         else div_d = DIV_W'(din);
      end
      // FSM assignments come last so a completing frame's done set wins over a DATA read
      case (state_q)
         IDLE: if (wr && reg_a == 3'd0) begin
            shreg_d  = din;
            mosi_d   = din[7];
            divcnt_d = '0;
            bitcnt_d = 3'd0;
            done_d   = 1'b0;
            state_d  = LOW;
         end
         LOW: if (term) begin
            divcnt_d = '0;
            sck_d    = 1'b1;
            rxbit_d  = miso;
            state_d  = HIGH;
         end else divcnt_d = divcnt_q + 1'b1;
         HIGH: if (term) begin
            divcnt_d = '0;
            sck_d    = 1'b0;
            shreg_d  = {shreg_q[6:0], rxbit_q};
            if (bitcnt_q == 3'd7) begin
               rxbuf_d = {shreg_q[6:0], rxbit_q};
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               bitcnt_d = bitcnt_q + 3'd1;
               mosi_d   = shreg_q[6];
               state_d  = LOW;
            end
         end else divcnt_d = divcnt_q + 1'b1;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge phi2 or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         sck_q    <= 1'b0;
         mosi_q   <= 1'b0;
         cs_q     <= 1'b0;
         done_q   <= 1'b0;
         ovr_q    <= 1'b0;
         rxbit_q  <= 1'b0;
         shreg_q  <= 8'h00;
         rxbuf_q  <= 8'h00;
         div_q    <= DIV_RESET;
         divcnt_q <= '0;
         bitcnt_q <= 3'd0;
      end else begin
         state_q  <= state_d;
         sck_q    <= sck_d;
         mosi_q   <= mosi_d;
         cs_q     <= cs_d;
         done_q   <= done_d;
         ovr_q    <= ovr_d;
         rxbit_q  <= rxbit_d;
         shreg_q  <= shreg_d;
         rxbuf_q  <= rxbuf_d;
         div_q    <= div_d;
         divcnt_q <= divcnt_d;
         bitcnt_q <= bitcnt_d;
      end
   end
endmodule

// File: tb/tb_cctl_spi_master.sv
// tb_cctl_spi_master: directed bench for the CCTL SPI master.
// A loopback or fixed-byte slave drives miso; cycle and sck-edge counters time the frames.
module tb_cctl_spi_master;
   logic phi2 = 1'b0, reset_n = 1'b0, sel = 1'b0, r_w = 1'b1;
   logic [2:0] reg_a = 3'd0;
   logic [7:0] din = 8'h00, dout, slv_byte = 8'h00, mosi_hist = 8'h00, v;
   logic sck, mosi, miso, cs_n, busy, lb = 1'b1;
   logic [127:0] samp;
   int checks = 0, failures = 0, rises = 0, rise_base = 0, busy_cyc = 0, b0 = 0, bad = 0;

   cctl_spi_master dut (.phi2(phi2), .reset_n(reset_n), .sel(sel), .reg_a(reg_a), .r_w(r_w),
      .din(din), .dout(dout), .sck(sck), .mosi(mosi), .miso(miso), .cs_n(cs_n), .busy(busy));

   always #5 phi2 = ~phi2;
   assign miso = lb ? mosi : slv_byte[3'(7 - (rises - rise_base))];
   always @(posedge sck) begin
      rises <= rises + 1;
      mosi_hist <= {mosi_hist[6:0], mosi};
   end
   always @(posedge phi2) if (busy) busy_cyc <= busy_cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      @(negedge phi2);
      sel = 1'b1; r_w = 1'b0; reg_a = a; din = d;
      @(negedge phi2);
      sel = 1'b0; r_w = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, output logic [7:0] d);
      @(negedge phi2);
      sel = 1'b1; r_w = 1'b1; reg_a = a;
      #1 d = dout;
      @(negedge phi2);
      sel = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 1000 && busy; i++) @(negedge phi2);
      check("idle_timeout", busy, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      #12;
      check("rst_sck", sck, 0);
      check("rst_cs_n", cs_n, 1);
      check("rst_busy", busy, 0);
      check("rst_mosi", mosi, 0);
      @(negedge phi2); reset_n = 1'b1;
      rd(3'd2, v); check("rst_div", v, 8'h03);
      rd(3'd1, v); check("rst_ctrl", v, 8'h00);
      rd(3'd0, v); check("rst_data", v, 8'h00);

      // loopback, DIV=0
      lb = 1'b1;
      wr(3'd2, 8'h00);
      b0 = busy_cyc; rise_base = rises;
      wr(3'd0, 8'hA5);
      wait_idle();
      check("lb_busy_cycles", busy_cyc - b0, 16);
      check("lb_sck_rises", rises - rise_base, 8);
      rd(3'd1, v); check("lb_ctrl_done", v, 8'h40);
      rd(3'd0, v); check("lb_data", v, 8'hA5);
      rd(3'd1, v); check("lb_ctrl_cleared", v, 8'h00);

      // fixed slave byte, DIV=2, CS asserted
      lb = 1'b0; slv_byte = 8'h3C;
      wr(3'd2, 8'h02);
      wr(3'd1, 8'h01);
      check("cs_assert", cs_n, 0);
      b0 = busy_cyc; rise_base = rises;
      wr(3'd0, 8'hCA);
      wait_idle();
      check("slv_busy_cycles", busy_cyc - b0, 48);
      check("slv_mosi_seq", mosi_hist, 8'hCA);
      rd(3'd1, v); check("slv_ctrl", v, 8'h41);
      rd(3'd0, v); check("slv_data", v, 8'h3C);

      // overrun: DATA write during a frame
      lb = 1'b1;
      b0 = busy_cyc;
      wr(3'd0, 8'h5A);
      repeat (3) @(negedge phi2);
      wr(3'd0, 8'hFF);
      wait_idle();
      check("ovr_busy_cycles", busy_cyc - b0, 48);
      rd(3'd1, v); check("ovr_ctrl", v, 8'h61);
      rd(3'd0, v); check("ovr_data", v, 8'h5A);
      wr(3'd1, 8'h81);
      rd(3'd1, v); check("ovr_cleared", v, 8'h01);
      // DIV write during a frame is dropped and flags overrun
      wr(3'd0, 8'h11);
      wr(3'd2, 8'h09);
      wait_idle();
      rd(3'd2, v); check("div_busy_hold", v, 8'h02);
      rd(3'd1, v); check("div_busy_ovr", v, 8'h61);
      rd(3'd0, v); check("div_busy_data", v, 8'h11);
      wr(3'd1, 8'h81);

      // DIV=7 phase timing
      wr(3'd2, 8'h07);
      rd(3'd2, v); check("div7_read", v, 8'h07);
      wr(3'd0, 8'h96);
      samp[0] = sck;
      for (int i = 1; i < 128; i++) begin
         @(negedge phi2);
         samp[i] = sck;
      end
      check("div7_busy_last", busy, 1);
      bad = 0;
      for (int i = 0; i < 128; i++) if (samp[i] !== 1'((i / 8) % 2)) bad++;
      check("div7_phase_errs", bad, 0);
      @(negedge phi2);
      check("div7_done_at_128", busy, 0);
      rd(3'd0, v); check("div7_data", v, 8'h96);

      // unused registers
      rd(3'd5, v); check("reg5_read", v, 8'h00);
      rd(3'd3, v); check("reg3_read", v, 8'h00);
      wr(3'd6, 8'hFF);
      rd(3'd1, v); check("reg6_ctrl", v, 8'h01);
      rd(3'd2, v); check("reg6_div", v, 8'h07);
      rd(3'd0, v); check("reg6_data", v, 8'h96);

      // asynchronous reset mid-frame at bit 4 with sck high
      wr(3'd2, 8'h03);
      wr(3'd0, 8'h55);
      repeat (37) @(negedge phi2);
      check("pre_rst_sck", sck, 1);
      check("pre_rst_cs_n", cs_n, 0);
      #2 reset_n = 1'b0;
      #1;
      check("arst_sck", sck, 0);
      check("arst_cs_n", cs_n, 1);
      check("arst_busy", busy, 0);
      @(negedge phi2); reset_n = 1'b1;
      rd(3'd2, v); check("arst_div", v, 8'h03);
      rd(3'd1, v); check("arst_ctrl", v, 8'h00);
      rd(3'd0, v); check("arst_data", v, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
